// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU with an accumulator-style operand and a
//               tri-stated result bus. Single-cycle ADD/SUB/logic/shift ops;
//               MUL is an iterative shift-add over WIDTH clock edges.
//               Result and {N,C,Z} flags are held until the next completion.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             out_en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  // Multiplier operand (latched b), consumed LSB first by shifting right.
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  // Multiplicand (latched a), shifted left one place per iteration.
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2:0]           flags_q, flags_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       diff_ext;
  logic [2*WIDTH-1:0]   prod_next;

  // Single-cycle datapath on the live operands; only used on the start edge.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];          // borrow: set iff a < b
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the current bit is set.
  always_comb begin
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and registered-output logic for the IDLE/MUL/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mplier_d = b;
            mcand_d  = {{WIDTH{1'b0}}, a};
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
            busy_d   = 1'b1;
          end else begin
            result_d = alu_res;
            flags_d  = {alu_res[WIDTH-1], alu_c, (alu_res == '0)};
            state_d  = S_DONE;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last iteration: commit the low half, C reports overflow into the high half.
          result_d = prod_next[WIDTH-1:0];
          flags_d  = {prod_next[WIDTH-1], (|prod_next[2*WIDTH-1:WIDTH]),
                      (prod_next[WIDTH-1:0] == '0)};
          state_d  = S_DONE;
          done_d   = 1'b1;
        end else begin
          busy_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any multiply and clears result and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign flags = flags_q;
  // The held result drives the bus whenever enabled, regardless of state.
  assign out   = out_en ? result_q : {WIDTH{1'bz}};

endmodule
`default_nettype wire
